// File: rtl/distram_nrport_2wport_pkg.sv
// ---------------------------------------------------------------------------
// distram_nrport_2wport_pkg
// Purpose : shared default sizes and an index-width helper for the
//           multi-read / dual-write distributed RAM and its storage banks.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package distram_nrport_2wport_pkg;

    localparam int DEF_INNER_WIDTH = 32;
    localparam int DEF_OUTER_WIDTH = 32;
    localparam int DEF_NUM_RPORTS  = 4;

    // Index width for a given entry count; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/distram_nrport_2wport_bank.sv
// ---------------------------------------------------------------------------
// distram_bank
// Purpose : one storage bank: a flop/LUT array with a single synchronous
//           write port and NRD independent combinational read ports.
// Ports   : i_clk                       clock
//           i_wen / i_windex / i_wdata  write enable, index, data
//           i_rindex[NRD]               read indices
//           o_rdata[NRD]                read data (combinational)
// ---------------------------------------------------------------------------
module distram_bank
    import distram_nrport_2wport_pkg::*;
#(
    parameter  int WIDTH = DEF_INNER_WIDTH,
    parameter  int DEPTH = DEF_OUTER_WIDTH,
    parameter  int NRD   = DEF_NUM_RPORTS + 1,
    localparam int IW    = idx_width(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_wen,
    input  logic [IW-1:0]             i_windex,
    input  logic [WIDTH-1:0]          i_wdata,
    input  logic [NRD-1:0][IW-1:0]    i_rindex,
    output logic [NRD-1:0][WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wen) begin
            r_mem[i_windex] <= i_wdata;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        assign o_rdata[g] = r_mem[i_rindex[g]];
    end

endmodule

// File: rtl/distram_nrport_2wport.sv
// ---------------------------------------------------------------------------
// distram_nrport_2wport
// Purpose : NUM_RPORTS-read / 2-write distributed RAM built from two
//           single-write banks plus a live-value table (LVT) recording which
//           bank last wrote each entry. After reset a sweep zeroes every
//           entry before ready rises.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_CLEAR | sweeping clear_index over both banks and LVT, writes ignored
//   ST_READY | normal operation, both write ports live
//
// Ports   : CLK, RST                  clock, synchronous active-high reset
//           rindex[NUM_RPORTS]        read indices
//           rdata[NUM_RPORTS]         read data (0 while not ready)
//           wen0/windex0/wdata0       write port 0
//           wen1/windex1/wdata1       write port 1 (wins on same-index write)
//           ready                     clear sweep complete
// ---------------------------------------------------------------------------
module distram_nrport_2wport
    import distram_nrport_2wport_pkg::*;
#(
    parameter  int INNER_WIDTH = DEF_INNER_WIDTH,
    parameter  int OUTER_WIDTH = DEF_OUTER_WIDTH,
    parameter  int NUM_RPORTS  = DEF_NUM_RPORTS,
    parameter  int RDATA_REG   = 0,
    parameter  int BYPASS      = 1,
    localparam int IW          = idx_width(OUTER_WIDTH)
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [NUM_RPORTS-1:0][IW-1:0]         rindex,
    output logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] rdata,
    input  logic                                  wen0,
    input  logic [IW-1:0]                         windex0,
    input  logic [INNER_WIDTH-1:0]                wdata0,
    input  logic                                  wen1,
    input  logic [IW-1:0]                         windex1,
    input  logic [INNER_WIDTH-1:0]                wdata1,
    output logic                                  ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_clear_idx;
    logic                   r_ready;
    logic [OUTER_WIDTH-1:0] r_lvt;

    logic w_clearing;
    logic w_wr0;
    logic w_wr1;

    // A write in the reset cycle itself would land in an array that is
    // about to be swept anyway, but blocking it keeps LVT and banks aligned.
    assign w_clearing = (r_state == ST_CLEAR) && !RST;
    assign w_wr0      = (r_state == ST_READY) && !RST && wen0;
    assign w_wr1      = (r_state == ST_READY) && !RST && wen1;

    // ---------------------------------------------------------------- banks
    logic                   w_b0_wen,  w_b1_wen;
    logic [IW-1:0]          w_b0_idx,  w_b1_idx;
    logic [INNER_WIDTH-1:0] w_b0_data, w_b1_data;

    assign w_b0_wen  = w_clearing | w_wr0;
    assign w_b0_idx  = w_clearing ? r_clear_idx : windex0;
    assign w_b0_data = w_clearing ? '0 : wdata0;
    assign w_b1_wen  = w_clearing | w_wr1;
    assign w_b1_idx  = w_clearing ? r_clear_idx : windex1;
    assign w_b1_data = w_clearing ? '0 : wdata1;

    // The spare read port on each bank follows the sweep pointer so the
    // entry being cleared is observable; nothing downstream consumes it.
    logic [NUM_RPORTS:0][IW-1:0]          w_bank_ridx;
    logic [NUM_RPORTS:0][INNER_WIDTH-1:0] w_b0_rdata, w_b1_rdata;
    logic                                 w_unused_sweep;

    always_comb begin
        w_bank_ridx = '0;
        for (int i = 0; i < NUM_RPORTS; i++) begin
            w_bank_ridx[i] = rindex[i];
        end
        w_bank_ridx[NUM_RPORTS] = r_clear_idx;
    end

    assign w_unused_sweep = ^{w_b0_rdata[NUM_RPORTS], w_b1_rdata[NUM_RPORTS]};

    distram_bank #(
        .WIDTH (INNER_WIDTH),
        .DEPTH (OUTER_WIDTH),
        .NRD   (NUM_RPORTS + 1)
    ) u_bank0 (
        .i_clk    (CLK),
        .i_wen    (w_b0_wen),
        .i_windex (w_b0_idx),
        .i_wdata  (w_b0_data),
        .i_rindex (w_bank_ridx),
        .o_rdata  (w_b0_rdata)
    );

    distram_bank #(
        .WIDTH (INNER_WIDTH),
        .DEPTH (OUTER_WIDTH),
        .NRD   (NUM_RPORTS + 1)
    ) u_bank1 (
        .i_clk    (CLK),
        .i_wen    (w_b1_wen),
        .i_windex (w_b1_idx),
        .i_wdata  (w_b1_data),
        .i_rindex (w_bank_ridx),
        .o_rdata  (w_b1_rdata)
    );

    // ------------------------------------------------------- FSM and LVT
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_CLEAR;
            r_clear_idx <= '0;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_lvt[r_clear_idx] <= 1'b0;
                    r_clear_idx        <= r_clear_idx + IW'(1);
                    if (r_clear_idx == IW'(OUTER_WIDTH - 1)) begin
                        r_state <= ST_READY;
                        r_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    // Port 1 assignment comes last so it wins a same-index tie.
                    if (wen0) r_lvt[windex0] <= 1'b0;
                    if (wen1) r_lvt[windex1] <= 1'b1;
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------ read path
    logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] w_rd_val;

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_RPORTS; i++) begin
            w_rd_val[i] = r_lvt[rindex[i]] ? w_b1_rdata[i] : w_b0_rdata[i];
            if (BYPASS != 0) begin
                if (w_wr1 && (windex1 == rindex[i])) begin
                    w_rd_val[i] = wdata1;
                end else if (w_wr0 && (windex0 == rindex[i])) begin
                    w_rd_val[i] = wdata0;
                end
            end
            if (!r_ready) begin
                w_rd_val[i] = '0;
            end
        end
    end

    if (RDATA_REG != 0) begin : g_rd_reg
        logic [NUM_RPORTS-1:0][INNER_WIDTH-1:0] r_rdata;

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_rd_val;
            end
        end

        assign rdata = r_rdata;
    end else begin : g_rd_comb
        assign rdata = w_rd_val;
    end

    assign ready = r_ready;

endmodule

// File: doc/distram_nrport_2wport.md
DISTRAM_NRPORT_2WPORT -- requirements
Module: distram_nrport_2wport

Interface
REQ-001 SHALL have parameter INNER_WIDTH, default 32, entry data width in bits.
REQ-002 SHALL have parameter OUTER_WIDTH, default 32, entry count (power of 2, >=2); index width IW = $clog2(OUTER_WIDTH).
REQ-003 SHALL have parameter NUM_RPORTS, default 4, number of independent read ports (>=1).
REQ-004 SHALL have parameter RDATA_REG, default 0; 0 = combinational read, 1 = one-cycle registered read.
REQ-005 SHALL have parameter BYPASS, default 1; 1 = same-cycle write data forwarded to matching reads.
REQ-006 SHALL have ports CLK in 1, clock; reset is synchronous and active-high.
REQ-007 SHALL have port RST in 1, synchronous active-high reset.
REQ-008 SHALL have ports rindex in [NUM_RPORTS][IW] and rdata out [NUM_RPORTS][INNER_WIDTH], per-port read index and data.
REQ-009 SHALL have ports wen0 in 1, windex0 in IW, wdata0 in INNER_WIDTH (write port 0).
REQ-010 SHALL have ports wen1 in 1, windex1 in IW, wdata1 in INNER_WIDTH (write port 1).
REQ-011 SHALL have port ready out 1, high once the post-reset clear sequence is complete.

Function
REQ-012 SHALL implement a clear FSM with states CLEAR and READY; RST forces CLEAR with clear_index = 0.
REQ-013 SHALL, in CLEAR, zero entry clear_index in both banks and the live-value table (LVT = 0) each cycle, then increment clear_index.
REQ-014 SHALL transition CLEAR -> READY on the cycle clear_index = OUTER_WIDTH-1 is cleared; ready rises exactly OUTER_WIDTH cycles after the last RST-high cycle.
REQ-015 SHALL ignore wen0/wen1 while in CLEAR and drive every rdata to 0 while ready = 0.
REQ-016 SHALL, in READY, on wen0 write wdata0 to bank0[windex0] and set LVT[windex0] = 0 at posedge CLK.
REQ-017 SHALL, in READY, on wen1 write wdata1 to bank1[windex1] and set LVT[windex1] = 1 at posedge CLK.
REQ-018 SHALL, when wen0 and wen1 target the same index in the same cycle, have port1 win (LVT = 1, later reads return wdata1).
REQ-019 SHALL return rdata[i] = bank[LVT[rindex[i]]][rindex[i]]; all read ports independent, any index aliasing allowed.
REQ-020 SHALL, with BYPASS = 1, return the same-cycle write data when rindex[i] matches an active write index (port1 over port0); with BYPASS = 0, return pre-write contents.
REQ-021 SHALL, with RDATA_REG = 0, make rdata a combinational function of rindex and state (zero latency).
REQ-022 SHALL, with RDATA_REG = 1, register the REQ-019/020 value so rdata reflects rindex sampled at the previous edge (latency 1).
REQ-023 SHALL never alter stored contents on read; writes take effect at the clock edge only.

Reset
REQ-024 SHALL, on RST, set ready = 0, FSM = CLEAR, clear_index = 0, registered rdata (RDATA_REG = 1) = 0.
REQ-025 SHALL restart the clear sequence from index 0 if RST asserts mid-clear or in READY; array contents are undefined until cleared.
REQ-026 SHALL, when INIT-free, produce all-zero reads for every index once ready = 1 and before any write.

Structure
REQ-027 SHALL place no typedefs in a shared package; FSM state enum local, all widths derived from parameters.
REQ-028 SHALL use one sub-module distram_bank (1 write port, NUM_RPORTS+1 combinational read ports) instantiated twice; LVT is a flop array in the top.

Verification
REQ-029 SHALL test reset: RST 1 cycle, OUTER_WIDTH=32 -> ready low 32 cycles then high; all rdata = 0 throughout and after.
REQ-030 SHALL test write/read: wen0 idx 5 data 0xA5A5A5A5, next cycle rindex[0..3]=5 -> all 0xA5A5A5A5 (RDATA_REG=0).
REQ-031 SHALL test conflict: wen0 idx 7 0x11, wen1 idx 7 0x22 same cycle -> later read idx 7 = 0x22; then wen0 idx 7 0x33 -> 0x33.
REQ-032 SHALL test bypass: BYPASS=1, wen1 idx 3 0xBEEF with rindex[2]=3 same cycle -> rdata[2] = 0xBEEF; BYPASS=0 -> old value.
REQ-033 SHALL test registered mode: RDATA_REG=1, rindex[1] changes 4 -> 9 -> rdata[1] shows idx 9 contents one cycle later.
REQ-034 SHALL test reset mid-clear: RST at clear_index 10 -> ready rises OUTER_WIDTH cycles after RST drop; writes during CLEAR lost.
